lcd_msg_arbiter: RTL

Shares the 32-character LCD message buffer between NREQ message sources, such as laser status and user/switch messages. It arbitrates between requesters and copies the winner's 32 bytes into an internal buffer. It then enforces a minimum display time before the next message may overwrite the buffer. The LCD display controller reads the buffer through a raddr/dout port, in the same way it reads the static message ROM.

---
 rtl/lcd_pkg.sv | 19 +
 rtl/lcd_msg_arbiter_if.sv | 29 ++
 rtl/lcd_msg_arbiter_rr_arbiter.sv | 29 ++
 rtl/lcd_msg_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and pointer helper for the LCD message arbiter.
package lcd_pkg;
    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 5;
    localparam int CHAR_W  = 8;
    localparam int IDX_W   = 2;
    localparam logic [CHAR_W-1:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Round-robin successor of a requester index, wrapping at nreq.
    function automatic logic [IDX_W-1:0] next_ptr(logic [IDX_W-1:0] idx, int nreq);
        return (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/lcd_msg_arbiter_if.sv
// Bus between the message arbiter, its message sources and the LCD display controller.
interface lcd_msg_arbiter_if
    import lcd_pkg::*;
#(
    parameter int NREQ = 2
);
    // Handshake: req is a level request; grant is one-hot and held for the whole
    // 33-cycle fetch and is never revoked. While granted, a source presents the byte
    // for src_addr one cycle later on its src_data lane. done pulses once per load.
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        grant;
    logic [ADDR_W-1:0]      src_addr;
    logic [NREQ*CHAR_W-1:0] src_data;
    logic                   done;
    logic                   busy;
    logic [1:0]             msg_owner;
    logic [ADDR_W-1:0]      raddr;
    logic [CHAR_W-1:0]      dout;

    modport master (
        input  req, src_data, raddr,
        output grant, src_addr, done, busy, msg_owner, dout
    );

    modport slave (
        output req, src_data, raddr,
        input  grant, src_addr, done, busy, msg_owner, dout
    );
endinterface

// File: rtl/lcd_msg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int off = 0; off < NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                any       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/lcd_msg_arbiter.sv
// Arbitrates NREQ message sources into a 32-byte LCD buffer with a minimum display hold.
// Optional macro LCD_MSG_PREEMPT_EN: a lower-index requester cuts the hold short.
module lcd_msg_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int HOLD_CYCLES = 50000000,
    parameter int HOLD_W      = 26
) (
    input  logic          CLOCK_50,
    input  logic          RESET,
    lcd_msg_arbiter_if.master bus,
    output state_t        state_dbg
);
    localparam logic [5:0]        FETCH_LAST = 6'd32;
    localparam logic [HOLD_W-1:0] HOLD_LOAD  =
        (HOLD_CYCLES == 0) ? '0 : HOLD_W'(HOLD_CYCLES - 1);

    state_t               state, state_n;
    logic [NREQ-1:0]      grant_r;
    logic [IDX_W-1:0]     winner, ptr, owner;
    logic [5:0]           fetch_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [ADDR_W-1:0]    src_addr_r;
    logic                 done_r;
    logic [CHAR_W-1:0]    buffer [MSG_LEN];

    logic [NREQ-1:0]      arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;
    logic                 start_burst, last_write, preempt;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

`ifdef LCD_MSG_PREEMPT_EN
    always_comb begin
        preempt = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i < int'(owner) && bus.req[i]) preempt = 1'b1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        start_burst = 1'b0;
        last_write  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    start_burst = 1'b1;
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                if (fetch_cnt == FETCH_LAST) begin
                    last_write = 1'b1;
                    state_n    = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (preempt || hold_cnt == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    // Data for src_addr k arrives one cycle later, so fetch count k+1 writes byte k.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            grant_r    <= '0;
            winner     <= '0;
            ptr        <= '0;
            owner      <= '0;
            fetch_cnt  <= '0;
            hold_cnt   <= '0;
            src_addr_r <= '0;
            done_r     <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) buffer[i] <= CHAR_SPACE;
        end else begin
            done_r <= last_write;
            if (start_burst) begin
                grant_r    <= arb_gnt;
                winner     <= arb_idx;
                src_addr_r <= '0;
                fetch_cnt  <= '0;
            end
            if (state == FETCH) begin
                fetch_cnt  <= fetch_cnt + 6'd1;
                src_addr_r <= (fetch_cnt >= 6'd31) ? 5'd31 : 5'(fetch_cnt + 6'd1);
                if (fetch_cnt != '0)
                    buffer[5'(fetch_cnt - 6'd1)] <= bus.src_data[winner*CHAR_W +: CHAR_W];
            end
            if (last_write) begin
                grant_r    <= '0;
                src_addr_r <= '0;
                owner      <= winner;
                ptr        <= next_ptr(winner, NREQ);
                hold_cnt   <= HOLD_LOAD;
            end
            if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign bus.grant     = grant_r;
    assign bus.src_addr  = src_addr_r;
    assign bus.done      = done_r;
    assign bus.busy      = (state != IDLE);
    assign bus.msg_owner = owner;
    assign bus.dout      = buffer[bus.raddr];
    assign state_dbg     = state;
endmodule
